// File: rtl/seq_mult32.sv
// Unsigned 32x32->64 shift-and-add multiplier reusing one bit32_fadder ripple adder.
// 32 iterations after the accepting edge; start is ignored while busy, done pulses for one cycle.

module bit32_fadder (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        cin,
  output logic [31:0] s,
  output logic        c
);
  logic [32:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign s[i]       = in1[i] ^ in2[i] ^ carry[i];
    assign carry[i+1] = (in1[i] & in2[i]) | (carry[i] & (in1[i] ^ in2[i]));
  end

  assign c = carry[32];
endmodule

module seq_mult32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] product_o
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] m_q, m_d;
  logic [31:0] a_q, a_d;
  logic [31:0] q_q, q_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [63:0] product_q, product_d;

  logic [31:0] sum;
  logic        sum_c;

  bit32_fadder u_add (
    .in1 (a_q),
    .in2 (m_q),
    .cin (1'b0),
    .s   (sum),
    .c   (sum_c)
  );

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          m_d     = a_i;
          q_d     = b_i;
          a_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Carry-out lands in A[31] so the 64-bit result is exact.
        if (q_q[0]) {a_d, q_d} = {sum_c, sum, q_q[31:1]};
        else        {a_d, q_d} = {1'b0, a_q, q_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          product_d = {a_d, q_d};
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = product_q;
endmodule

// File: tb/tb_seq_mult32.sv
// Directed bench for seq_mult32: latency, busy/done handshake, ignored start, back-to-back, reset abort.
`timescale 1ns/1ps
module tb_seq_mult32;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, done_o;
  logic [63:0] product_o;

  int checks = 0;
  int errors = 0;

  seq_mult32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .product_o (product_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One operation from a start pulse; optionally fires a second start mid-run.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit interfere);
    int          done_k;
    int          busy_cnt;
    int          extra_done;
    bit          stable;
    logic [63:0] prod_before;
    prod_before = product_o;
    done_k      = 0;
    busy_cnt    = 0;
    stable      = 1'b1;
    start_i = 1'b1; a_i = a; b_i = b;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin start_i = 1'b0; a_i = 32'hDEAD_BEEF; b_i = 32'hCAFE_F00D; end
      if (interfere && k == 10) begin start_i = 1'b1; a_i = 32'd2; b_i = 32'd2; end
      if (interfere && k == 11) start_i = 1'b0;
      if (busy_o) busy_cnt++;
      if (done_o) done_k = k;
      else if (product_o !== prod_before) stable = 1'b0;
    end
    chk({tag, "_done_cycle"}, 64'(done_k), 64'd33);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    chk({tag, "_product_stable"}, {63'd0, stable}, 64'd1);
    chk({tag, "_product"}, product_o, exp);
    chk({tag, "_busy_at_done"}, {63'd0, busy_o}, 64'd0);
    extra_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_o) extra_done++;
    end
    chk({tag, "_no_extra_done"}, 64'(extra_done), 64'd0);
    chk({tag, "_product_hold"}, product_o, exp);
  endtask

  initial begin
    int          d1, d2, gap, spurious;
    logic [63:0] p1, p2;
    rst_n = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0;
    #1;
    chk("reset_busy", {63'd0, busy_o}, 64'd0);
    chk("reset_done", {63'd0, done_o}, 64'd0);
    chk("reset_product", product_o, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);
    run_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op("mul_ident", 32'h1234_5678, 32'd1, 64'h0000_0000_1234_5678, 1'b0);
    run_op("mul_zero", 32'h1234_5678, 32'd0, 64'd0, 1'b0);
    run_op("ignore_start", 32'd7, 32'd9, 64'd63, 1'b1);

    // Back-to-back with start held high; operands switch once the first is accepted.
    d1 = 0; d2 = 0; gap = 0; p1 = '0; p2 = '0;
    start_i = 1'b1; a_i = 32'h8000_0000; b_i = 32'd2;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 1) begin a_i = 32'd6; b_i = 32'd7; end
      if (k == 34) start_i = 1'b0;
      if (k <= 66 && !(busy_o || done_o)) gap++;
      if (done_o && d1 == 0) begin d1 = k; p1 = product_o; end
      else if (done_o && d2 == 0) begin d2 = k; p2 = product_o; end
    end
    chk("b2b_first_done", 64'(d1), 64'd33);
    chk("b2b_first_product", p1, 64'h0000_0001_0000_0000);
    chk("b2b_second_done", 64'(d2), 64'd66);
    chk("b2b_second_product", p2, 64'd42);
    chk("b2b_no_idle_gap", 64'(gap), 64'd0);

    // Reset in the middle of an operation aborts it.
    start_i = 1'b1; a_i = 32'd100; b_i = 32'd100;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
    end
    chk("pre_abort_busy", {63'd0, busy_o}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy_o}, 64'd0);
    chk("abort_done", {63'd0, done_o}, 64'd0);
    chk("abort_product", product_o, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_o || busy_o) spurious++;
    end
    chk("abort_no_done", 64'(spurious), 64'd0);
    run_op("after_abort", 32'd100, 32'd100, 64'd10000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
